div32_seq: RTL and testbench
============================

Name: div32_seq

Overview:
- Multi-cycle 32-bit divider for the MiniMIPS execute stage; backs DIV/DIVU and writes the HI/LO pair.
- Uses the same operation as the existing set-less-than datapath, but in the opposite direction: the subtract result's sign drives the quotient bit instead of being the final answer.
- Restoring algorithm, one quotient bit per clock, with a start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported.
- CNT_W, 5, iteration counter width; log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  request a divide; sampled only when not busy.
- is_signed  in  1  1 = DIV, 0 = DIVU. Ignored unless the optional feature is compiled in.
- dividend  in  32  captured on an accepted start.
- divisor  in  32  captured on an accepted start.
- busy  out  1  high while a divide is in progress.
- done  out  1  results valid; held high until the next accepted start or reset.
- quotient  out  32  written to LO.
- remainder  out  32  written to HI.
- div_by_zero  out  1  last accepted divide had divisor == 0; valid while done is high.

Behaviour:
- Reset: on a reset edge, state = IDLE and busy, done, quotient, remainder, div_by_zero all = 0. This applies in any state, including mid-RUN; any in-flight divide is discarded.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE only.
  - On the accepting edge: operands are latched, done drops to 0, the counter is cleared to 0 and busy rises.
  - start is ignored while in RUN.
- Divide by zero (latched divisor == 0):
  - The accepting edge goes directly to DONE; no RUN cycles.
  - Results: quotient = 0xFFFFFFFF, remainder = dividend, div_by_zero = 1.
  - done is seen one cycle after the start edge.
- RUN step, one per cycle:
  - partial = {rem[30:0], dq[31]}; dq shifts left.
  - If partial minus divisor does not borrow (partial >= divisor, unsigned): rem = partial − divisor and the new quotient LSB = 1.
  - Otherwise: rem = partial and the new quotient LSB = 0.
- Termination: after 32 steps (counter 0..31, wrap at 31) the FSM goes to DONE, busy = 0, done = 1 and outputs are registered.
- Latency: done rises at the 33rd rising edge after the start-accept edge (including that edge).
- Output hold: outputs and done are held in DONE indefinitely.
- Back-to-back: start asserted in the first DONE cycle is accepted, and the previous results stay on the outputs until the new done.
- Simultaneous start and reset: reset wins.
- Arithmetic: unsigned by default; all operations are mod 2^32.

Optional Feature:
- Macro: DIV32_SIGNED_EN.
- With the macro defined and is_signed = 1:
  - Operands are converted to magnitudes at accept time.
  - The quotient is negated if the operand signs differ; the remainder takes the dividend's sign. Both fixups happen in the final RUN step, so latency is unchanged.
  - 0x80000000 / 0xFFFFFFFF gives quotient = 0x80000000, remainder = 0.
  - Divide-by-zero results are the same as the unsigned case.
- Without the macro: is_signed is ignored and every divide is unsigned.

Decomposition:
- Package div32_pkg:
  - FSM state enum (IDLE, RUN, DONE).
  - WIDTH and CNT_W constants.
  - DIV_LATENCY = 33.
  - DIV0_QUOTIENT = 0xFFFFFFFF.
- Sub-module div32_step: combinational shift/compare/subtract for one quotient bit, built on sub32. Inputs rem, dq_msb, divisor; outputs next_rem, q_bit.
- The FSM, counter and registers live in div32_seq.

Test Plan:
- Basic divide: start with 100 / 7 → busy for 32 cycles, done at edge +33, quotient = 14, remainder = 2, div_by_zero = 0.
- Full-scale operand: 0xFFFFFFFF / 1 → quotient = 0xFFFFFFFF, remainder = 0. Then 3 / 0xFFFFFFFF → quotient = 0, remainder = 3.
- Divide by zero: 5 / 0 → done at edge +1, quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1, busy never seen high.
- Reset and ignored start:
  - Start 100 / 7; pulse reset at cycle 10 → next edge busy = done = 0 and outputs = 0.
  - Restart 9 / 3 → quotient = 3, remainder = 0.
  - Start pulsed at cycle 5 of a divide is ignored.
- Signed (DIV32_SIGNED_EN defined, is_signed = 1):
  - −7 / 2 → quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF.
  - 7 / −2 → quotient = 0xFFFFFFFD, remainder = 1.
  - 0x80000000 / −1 → quotient = 0x80000000, remainder = 0.
- Back-to-back: start 20 / 6 in the first DONE cycle after 100 / 7 → outputs hold 14 / 2 until the new done, then show 3 / 2.

Source files
------------

// File: rtl/div32_pkg.sv
// Shared types and constants for the div32_seq restoring divider.
// Signed support is compiled in with DIV32_SIGNED_EN.
package div32_pkg;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned DIV_LATENCY = 33;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement negate, mod 2^WIDTH.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return (~x) + WIDTH'(1);
    endfunction

endpackage

// File: rtl/div32_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract,
// keep the difference when it does not borrow.
module div32_step
    import div32_pkg::*;
(
    input  logic [WIDTH-1:0] rem,
    input  logic             dq_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    // rem < divisor before every non-final shift, so its MSB is always zero.
    logic             unused_rem_msb;

    assign unused_rem_msb = rem[WIDTH-1];
    assign partial        = {rem[WIDTH-2:0], dq_msb};

    sub32 u_sub (
        .a      (partial),
        .b      (divisor),
        .diff   (diff),
        .borrow (borrow)
    );

    assign q_bit    = ~borrow;
    assign next_rem = borrow ? partial : diff;

endmodule

// File: rtl/sub32.sv
// 32-bit subtractor with borrow out, shared with the set-less-than datapath.
module sub32
    import div32_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    always_comb begin
        {borrow, diff} = {1'b0, a} - {1'b0, b};
    end

endmodule

// File: rtl/div32_seq.sv
// Multi-cycle 32-bit restoring divider with start/busy/done handshake.
// Define DIV32_SIGNED_EN to honour is_signed (DIV); otherwise always DIVU.
module div32_seq
    import div32_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_d, done_d, dbz_d;
    logic [WIDTH-1:0] quotient_d, remainder_d;

    logic             signed_op;
    logic             dvd_neg, dsr_neg;
    logic [WIDTH-1:0] dvd_mag, dsr_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] shifted_q;

`ifdef DIV32_SIGNED_EN
    assign signed_op = is_signed;
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign signed_op        = 1'b0;
`endif

    // Signed operands are reduced to magnitudes at accept time.
    assign dvd_neg = signed_op & dividend[WIDTH-1];
    assign dsr_neg = signed_op & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? negate(dividend) : dividend;
    assign dsr_mag = dsr_neg ? negate(divisor)  : divisor;

    div32_step u_step (
        .rem      (rem_q),
        .dq_msb   (dq_q[WIDTH-1]),
        .divisor  (dsr_q),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    assign shifted_q = {dq_q[WIDTH-2:0], step_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            dsr_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            rem_q       <= rem_d;
            dq_q        <= dq_d;
            dsr_q       <= dsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            busy        <= busy_d;
            done        <= done_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            div_by_zero <= dbz_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rem_d       = rem_q;
        dq_d        = dq_q;
        dsr_d       = dsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        busy_d      = busy;
        done_d      = done;
        quotient_d  = quotient;
        remainder_d = remainder;
        dbz_d       = div_by_zero;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    done_d    = 1'b0;
                    cnt_d     = '0;
                    rem_d     = '0;
                    dq_d      = dvd_mag;
                    dsr_d     = dsr_mag;
                    neg_quo_d = dvd_neg ^ dsr_neg;
                    neg_rem_d = dvd_neg;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        quotient_d  = DIV0_QUOTIENT;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                dq_d  = shifted_q;
                cnt_d = cnt + CNT_W'(1);
                if (cnt == LAST_STEP) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    dbz_d       = 1'b0;
                    quotient_d  = neg_quo_q ? negate(shifted_q) : shifted_q;
                    remainder_d = neg_rem_q ? negate(step_rem)  : step_rem;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq; signed vectors run when
// DIV32_SIGNED_EN is defined.
module tb_div32_seq;
    import div32_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    div32_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Counts edges after the accept edge until done, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] eq, input logic [31:0] er);
        int c;
        pulse_start(a, b, s);
        wait_done(c);
        check({tag, " latency"}, 32'(c), 32'(DIV_LATENCY - 1));
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
    endtask

    initial begin
        int  c;
        bit  early;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset dbz", {31'd0, div_by_zero}, 32'd0);

        // 100 / 7 with cycle-exact busy/done window
        pulse_start(32'd100, 32'd7, 1'b0);
        check("basic busy after accept", {31'd0, busy}, 32'd1);
        check("basic done after accept", {31'd0, done}, 32'd0);
        early = 1'b0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (done || !busy) early = 1'b1;
        end
        check("basic run window", {31'd0, early}, 32'd0);
        @(negedge clk);
        check("basic done", {31'd0, done}, 32'd1);
        check("basic busy end", {31'd0, busy}, 32'd0);
        check("basic quotient", quotient, 32'd14);
        check("basic remainder", remainder, 32'd2);
        check("basic dbz", {31'd0, div_by_zero}, 32'd0);

        // back-to-back start in the first DONE cycle
        dividend = 32'd20;
        divisor  = 32'd6;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b done dropped", {31'd0, done}, 32'd0);
        check("b2b busy", {31'd0, busy}, 32'd1);
        check("b2b hold quotient", quotient, 32'd14);
        check("b2b hold remainder", remainder, 32'd2);
        wait_done(c);
        check("b2b latency", 32'(c), 32'd32);
        check("b2b quotient", quotient, 32'd3);
        check("b2b remainder", remainder, 32'd2);

        // output hold in DONE
        repeat (5) @(negedge clk);
        check("hold done", {31'd0, done}, 32'd1);
        check("hold quotient", quotient, 32'd3);

        run_div("fullscale/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
        run_div("3/fullscale", 32'd3, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd3);

        // divide by zero completes on the accept edge
        pulse_start(32'd5, 32'd0, 1'b0);
        check("div0 busy", {31'd0, busy}, 32'd0);
        check("div0 done", {31'd0, done}, 32'd1);
        check("div0 quotient", quotient, 32'hFFFF_FFFF);
        check("div0 remainder", remainder, 32'd5);
        check("div0 dbz", {31'd0, div_by_zero}, 32'd1);

        // reset mid-run discards the divide
        pulse_start(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun reset busy", {31'd0, busy}, 32'd0);
        check("midrun reset done", {31'd0, done}, 32'd0);
        check("midrun reset quotient", quotient, 32'd0);
        check("midrun reset remainder", remainder, 32'd0);
        check("midrun reset dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (3) @(negedge clk);
        check("after reset idle", {31'd0, busy | done}, 32'd0);

        // 9 / 3 with an ignored start at cycle 5
        pulse_start(32'd9, 32'd3, 1'b0);
        repeat (4) @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c);
        check("ignored start latency", 32'(c + 5), 32'd32);
        check("ignored start quotient", quotient, 32'd3);
        check("ignored start remainder", remainder, 32'd0);
        check("ignored start dbz", {31'd0, div_by_zero}, 32'd0);

        // reset wins over a simultaneous start
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("reset vs start busy", {31'd0, busy}, 32'd0);
        check("reset vs start done", {31'd0, done}, 32'd0);

`ifdef DIV32_SIGNED_EN
        run_div("signed -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("signed 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
        run_div("signed min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        run_div("unsigned in signed build", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1);
`else
        run_div("is_signed ignored", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1);
        run_div("unsigned min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
